// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath strobes.
// Define UPPER_IMM_EN to build the UPPER state for LUI/AUIPC; otherwise those opcodes trap.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t cur;
  state_t dispatch;
  logic   taken;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // Branches with funct3 010/011 have no defined condition and are treated as illegal.
  always_comb begin
    dispatch = S_TRAP;
    case (op)
      7'b0000011, 7'b0100011: dispatch = S_MEMADR;
      7'b0110011:             dispatch = S_EXECR;
      7'b0010011:             dispatch = S_EXECI;
      7'b1101111:             dispatch = S_JAL;
      7'b1100111:             dispatch = S_JALR;
      7'b1100011:             dispatch = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_BRANCH;
`ifdef UPPER_IMM_EN
      7'b0110111, 7'b0010111: dispatch = S_UPPER;
`else
      7'b0110111, 7'b0010111: dispatch = S_TRAP;
`endif
      default:                dispatch = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE:   cur <= dispatch;
        S_MEMADR:   cur <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWB:    cur <= S_FETCH;
        S_MEMWRITE: if (mem_ready) cur <= S_FETCH;
        S_EXECR:    cur <= S_ALUWB;
        S_ALUWB:    cur <= S_FETCH;
        S_EXECI:    cur <= S_ALUWB;
        S_JAL:      cur <= S_ALUWB;
        S_BRANCH:   cur <= S_FETCH;
        S_JALR:     cur <= S_JAL;
`ifdef UPPER_IMM_EN
        S_UPPER:    cur <= S_ALUWB;
`endif
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_TRAP;
      endcase
    end
  end

  // Moore decode; write strobes and illegal are suppressed while reset is held.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = taken;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
`ifdef UPPER_IMM_EN
      S_UPPER: begin
        ALUSrcA = op[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
`endif
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: per-instruction state paths from an opcode-class model, checked each cycle.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegWrite(RegWrite), .illegal(illegal), .state(state)
  );

  typedef enum {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_UPPER, C_ILL} cls_t;
  typedef struct { int st; int mr; bit rst; } ent_t;

  logic [17:0] expQ[$];
  int vectors = 0;
  int miscompares = 0;
  int monCycle = 0;
  logic [17:0] monExp;
  logic [13:0] monAct;

  function automatic cls_t classify(logic [6:0] o, logic [2:0] f3);
    if (o == 7'b0000011) return C_LOAD;
    if (o == 7'b0100011) return C_STORE;
    if (o == 7'b0110011) return C_R;
    if (o == 7'b0010011) return C_I;
    if (o == 7'b1101111) return C_JAL;
    if (o == 7'b1100111) return C_JALR;
    if (o == 7'b1100011) return (f3 == 3'b010 || f3 == 3'b011) ? C_ILL : C_BR;
`ifdef UPPER_IMM_EN
    if (o == 7'b0110111 || o == 7'b0010111) return C_UPPER;
`endif
    return C_ILL;
  endfunction

  function automatic bit refTaken(logic [2:0] f3, bit z, bit l, bit lu);
    bit cond;
    cond = f3[2] ? (f3[1] ? lu : l) : z;
    return f3[0] ? !cond : cond;
  endfunction

  // Expected strobes packed as {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,illegal}.
  function automatic logic [13:0] expOuts(int st, bit mr, bit rst, logic [6:0] o, logic [2:0] f3, bit z, bit l, bit lu);
    bit pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0;
    case (st)
      0:  begin sb = 2; rs = 2; pcw = mr; irw = mr; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; aop = 2; end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; aop = 2; end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; aop = 1; pcw = refTaken(f3, z, l, lu); end
      11: begin sa = 2; sb = 1; end
      12: begin sa = o[5] ? 2'd3 : 2'd1; sb = 1; end
      13: ill = 1;
      default: ;
    endcase
    if (rst) begin pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, ill};
  endfunction

  task automatic applyStimulus(input int st, input bit mr, input bit rst);
    reset = rst;
    mem_ready = mr;
    expQ.push_back({4'(st), expOuts(st, mr, rst, op, funct3, zero, lt, ltu)});
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH; abort ends a store stall with a reset, trapN sets TRAP dwell before reset.
  task automatic runInstr(input logic [6:0] iop, input logic [2:0] if3, input bit iz, input bit il,
                          input bit ilu, input int stF, input int stM, input bit abort, input int trapN);
    ent_t plan[$];
    bit mrv;
    op = iop; funct3 = if3; zero = iz; lt = il; ltu = ilu;
    repeat (stF) plan.push_back('{0, 0, 1'b0});
    plan.push_back('{0, 1, 1'b0});
    plan.push_back('{1, 2, 1'b0});
    case (classify(iop, if3))
      C_R:     begin plan.push_back('{6, 2, 1'b0}); plan.push_back('{7, 2, 1'b0}); end
      C_I:     begin plan.push_back('{8, 2, 1'b0}); plan.push_back('{7, 2, 1'b0}); end
      C_LOAD: begin
        plan.push_back('{2, 2, 1'b0});
        repeat (stM) plan.push_back('{3, 0, 1'b0});
        plan.push_back('{3, 1, 1'b0});
        plan.push_back('{4, 2, 1'b0});
      end
      C_STORE: begin
        plan.push_back('{2, 2, 1'b0});
        repeat (stM) plan.push_back('{5, 0, 1'b0});
        if (abort) plan.push_back('{5, 0, 1'b1});
        else plan.push_back('{5, 1, 1'b0});
      end
      C_BR:    plan.push_back('{10, 2, 1'b0});
      C_JAL:   begin plan.push_back('{9, 2, 1'b0}); plan.push_back('{7, 2, 1'b0}); end
      C_JALR:  begin plan.push_back('{11, 2, 1'b0}); plan.push_back('{9, 2, 1'b0}); plan.push_back('{7, 2, 1'b0}); end
      C_UPPER: begin plan.push_back('{12, 2, 1'b0}); plan.push_back('{7, 2, 1'b0}); end
      default: begin
        repeat (trapN) plan.push_back('{13, 2, 1'b0});
        plan.push_back('{13, 2, 1'b1});
      end
    endcase
    foreach (plan[i]) begin
      mrv = (plan[i].mr == 2) ? 1'($urandom % 2) : 1'(plan[i].mr);
      applyStimulus(plan[i].st, mrv, plan[i].rst);
    end
  endtask

  task automatic checkOutput();
    monExp = expQ.pop_front();
    monAct = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal};
    vectors++;
    if (state !== monExp[17:14]) begin
      miscompares++;
      $display("[TB] FAIL state cycle %0d: got %0d expected %0d", monCycle, state, monExp[17:14]);
    end
    vectors++;
    if (monAct !== monExp[13:0]) begin
      miscompares++;
      $display("[TB] FAIL strobes cycle %0d (state %0d): got %b expected %b", monCycle, monExp[17:14], monAct, monExp[13:0]);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput();
      monCycle++;
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] timeout");
  end

  logic [6:0] legalOps [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] rop;
    int idx;
    reset = 1'b1; op = 0; funct3 = 0; zero = 0; lt = 0; ltu = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 1, 1'b1);

    runInstr(7'b0100011, 3'b010, 0, 0, 0, 0, 1, 1'b1, 0);
    runInstr(7'b0000011, 3'b010, 0, 0, 0, 0, 2, 1'b0, 0);
    runInstr(7'b1100011, 3'b001, 0, 0, 0, 0, 0, 1'b0, 0);
    runInstr(7'b1100011, 3'b001, 1, 0, 0, 1, 0, 1'b0, 0);
    runInstr(7'b1100011, 3'b010, 0, 0, 0, 0, 0, 1'b0, 3);
    runInstr(7'b1100111, 3'b000, 0, 0, 0, 0, 0, 1'b0, 0);
    runInstr(7'b0110111, 3'b000, 0, 0, 0, 0, 0, 1'b0, 2);
    runInstr(7'b0010111, 3'b000, 0, 0, 0, 0, 0, 1'b0, 2);
    runInstr(7'b0000000, 3'b000, 0, 0, 0, 0, 0, 1'b0, 20);

    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, 9);
      if (idx == 9) rop = 7'($urandom);
      else rop = legalOps[idx];
      runInstr(rop, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), ($urandom % 8) == 0,
               $urandom_range(1, 4));
    end

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RISC-V core. It sits beside the immediate-source decoder in the control unit and consumes the same instruction opcode from the instruction register. It sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath strobe and mux select. It also resolves branches from ALU flags, stalls on memory, and traps on illegal opcodes.

## Interface
Parameters: none.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- op  input  7  opcode field of the instruction register
- funct3  input  3  instruction funct3 (used for branch condition)
- zero  input  1  ALU result == 0
- lt  input  1  ALU signed less-than flag
- ltu  input  1  ALU unsigned less-than flag
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  Result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  SrcA mux: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
- ALUSrcB  output  2  SrcB mux: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  00 = add, 01 = subtract (branch), 10 = decode by funct
- RegWrite  output  1  register file write enable
- illegal  output  1  core trapped on an illegal instruction
- state  output  4  current state encoding (debug)

## Operation
- The state register is 4 bits. Outputs are a Moore decode of the state, except for the mem_ready gating and the branch term noted below.
- States and their asserted outputs (anything not listed is 0):
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite = mem_ready. Go to DECODE when mem_ready, else stay.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00. This precomputes the branch/JAL target into ALUOut. Dispatch on op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - anything else → TRAP
    - funct3 of 010 or 011 with op=1100011 → TRAP
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite. Go to FETCH.
  - MEMWRITE(5): AdrSrc=1, MemWrite. MemWrite is held asserted until mem_ready, then go to FETCH.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - ALUWB(7): ResultSrc=00, RegWrite. Go to FETCH.
  - EXECI(8): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite. This writes the target to PC and computes OldPC+4. Go to ALUWB.
  - BRANCH(10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = taken. Go to FETCH.
  - JALR(11): ALUSrcA=10, ALUSrcB=01, ALUOp=00. This computes RD1+imm into ALUOut. Go to JAL. Clearing bit 0 of the target is the datapath's job.
  - UPPER(12): ALUSrcA = 11 if op[5]=1 (LUI), 01 if op[5]=0 (AUIPC). ALUSrcB=01, ALUOp=00. Go to ALUWB.
  - TRAP(13): all strobes 0, illegal=1. Stays in TRAP until reset.
- Branch condition `taken`, by funct3:
  - 000 → zero
  - 001 → !zero
  - 100 → lt
  - 101 → !lt
  - 110 → ltu
  - 111 → !ltu
- Unused encodings 14 and 15 go to TRAP on the next edge.

## Timing
- Reset:
  - The state goes to FETCH on the first rising edge with reset=1.
  - While reset=1, PCWrite, MemWrite, IRWrite, RegWrite and illegal are forced to 0 regardless of state.
  - Reset asserted mid-instruction aborts it with no further strobes.
- Cycle counts with mem_ready tied to 1:
  - R, I, JAL, LUI, AUIPC: 4 cycles
  - JALR: 5
  - BRANCH: 3
  - SW: 4
  - LW: 5
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No strobe may double-fire during a stall.
- mem_ready is ignored in every other state.

## Configuration
- UPPER_IMM_EN defined: LUI and AUIPC dispatch to UPPER as described above.
- UPPER_IMM_EN undefined: UPPER is not built, and opcodes 0110111 and 0010111 go from DECODE to TRAP.

## Test plan
- Reset mid-MEMWRITE with mem_ready=0: MemWrite drops to 0 during reset, and state=0 after the edge.
- op=0000011, mem_ready low for 2 cycles in MEMREAD: state sequence is 0,1,2,3,3,3,4,0. RegWrite is high only in state 4.
- op=1100011: with funct3=001 and zero=0, PCWrite=1 in BRANCH. With zero=1, PCWrite=0. With funct3=010, DECODE goes to 13 and illegal=1 until reset.
- op=1100111: state sequence is 0,1,11,9,7,0. PCWrite is high in 9, and RegWrite is high in 7.
- op=0110111: ALUSrcA=11 in state 12 when the macro is defined. Without the macro, the state goes to 13.
- op=0000000: DECODE goes to TRAP. All write strobes stay 0 for 20 cycles, and illegal=1.
